// File: rtl/sha3_msg_padder.sv
// Packs a 64-bit message word stream into 1088-bit SHA3-256 rate blocks, applies pad10*1
// and hands each block to the core through its in_valid / hash_next / out_valid handshake.
module sha3_msg_padder #(
   parameter int         W          = 64,
   parameter int         RATE_WORDS = 17,
   parameter logic [7:0] DOMAIN     = 8'h06
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      msg_valid,
   output logic                      msg_ready,
   input  logic [W-1:0]              msg_data,
   input  logic                      msg_last,
   input  logic [3:0]                msg_bytes,
   output logic [RATE_WORDS*W-1:0]   core_in,
   output logic                      core_in_valid,
   output logic                      core_more,
   input  logic                      core_hash_next,
   input  logic                      core_out_valid,
   output logic                      busy
);

   localparam int RATE_BITS  = RATE_WORDS * W;
   localparam int RATE_BYTES = RATE_BITS / 8;
   localparam int WORD_BYTES = W / 8;
   localparam int IDX_W      = $clog2(RATE_WORDS + 1);
   localparam int BPOS_W     = $clog2(RATE_BYTES + 1);

   typedef enum logic [1:0] {FILL, ISSUE, PADBLK} state_t;

   state_t               state_q, state_d;
   logic [IDX_W-1:0]     idx_q;
   // Block held in natural order: message byte n at blk_q[8n+7:8n]
   logic [RATE_BITS-1:0] blk_q, blk_d;
   logic                 more_q;
   logic                 pad_pend_q;
   logic                 first_q;
   logic                 core_idle_q;
   logic                 busy_q;
   logic                 accept;
   logic                 issue;
   logic                 lane_full;
   logic [3:0]           nbytes;
   logic [BPOS_W-1:0]    bpos;
   logic [W-1:0]         lane;

   function automatic logic [3:0] clamp_bytes(input logic [3:0] b);
      return (b > 4'(WORD_BYTES)) ? 4'(WORD_BYTES) : b;
   endfunction

   // The core expects each byte bit-reversed, byte 0 at the top: a full-vector bit reversal
   function automatic logic [RATE_BITS-1:0] core_order(input logic [RATE_BITS-1:0] v);
      logic [RATE_BITS-1:0] r;
      r = '0;
      for (int i = 0; i < RATE_BITS; i++) r[RATE_BITS-1-i] = v[i];
      return r;
   endfunction

   assign nbytes    = clamp_bytes(msg_bytes);
   assign bpos      = BPOS_W'({idx_q, 3'b000}) + BPOS_W'(nbytes);
   assign lane_full = (idx_q == IDX_W'(RATE_WORDS - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= FILL;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         FILL:    if (accept && (msg_last || lane_full)) state_d = ISSUE;
         ISSUE:   if (issue) state_d = pad_pend_q ? PADBLK : FILL;
         PADBLK:  state_d = ISSUE;
         default: state_d = FILL;
      endcase
   end

   // First block of a message goes to an idle core; continuation blocks wait for hash_next
   always_comb begin
      msg_ready     = (state_q == FILL);
      accept        = msg_ready && msg_valid;
      issue         = (state_q == ISSUE) && (first_q ? core_idle_q : core_hash_next);
      core_in_valid = issue;
      core_more     = more_q;
      busy          = busy_q;
      core_in       = core_order(blk_q);
   end

   always_comb begin
      blk_d = blk_q;
      lane  = '0;
      if (issue) begin
         blk_d = '0;
      end else if (state_q == PADBLK) begin
         blk_d                   = '0;
         blk_d[7:0]              = DOMAIN;
         blk_d[RATE_BITS-1 -: 8] = 8'h80;
      end else if (accept) begin
         for (int k = 0; k < WORD_BYTES; k++)
            lane[8*k +: 8] = (!msg_last || k < int'(nbytes)) ? msg_data[8*k +: 8] : 8'h00;
         blk_d[int'(idx_q)*W +: W] = lane;
         // A full last block carries no padding; it moves to a pad-only block
         if (msg_last && int'(bpos) < RATE_BYTES) begin
            blk_d[int'(bpos)*8 +: 8]  = blk_d[int'(bpos)*8 +: 8] ^ DOMAIN;
            blk_d[RATE_BITS-1 -: 8]   = blk_d[RATE_BITS-1 -: 8] | 8'h80;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx_q       <= '0;
         blk_q       <= '0;
         more_q      <= 1'b0;
         pad_pend_q  <= 1'b0;
         first_q     <= 1'b1;
         core_idle_q <= 1'b1;
         busy_q      <= 1'b0;
      end else begin
         blk_q <= blk_d;
         if (accept) begin
            idx_q  <= idx_q + 1'b1;
            busy_q <= 1'b1;
            if (msg_last) begin
               more_q     <= (int'(bpos) == RATE_BYTES);
               pad_pend_q <= (int'(bpos) == RATE_BYTES);
            end else if (lane_full) begin
               more_q     <= 1'b1;
               pad_pend_q <= 1'b0;
            end
         end
         if (state_q == PADBLK) begin
            more_q     <= 1'b0;
            pad_pend_q <= 1'b0;
         end
         if (issue) begin
            idx_q   <= '0;
            first_q <= !more_q;
            if (!more_q) busy_q <= 1'b0;
            if (first_q) core_idle_q <= 1'b0;
         end
         if (core_out_valid) core_idle_q <= 1'b1;
      end
   end

endmodule

// File: tb/tb_sha3_msg_padder.sv
// Randomized scoreboard bench for sha3_msg_padder with a behavioural pad10*1 model
// and a simple model of the SHA3 core handshake.
`timescale 1ns/1ps
module tb_sha3_msg_padder;

   localparam int RB   = 136;
   localparam int BITS = 1088;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            msg_valid;
   logic            msg_ready;
   logic [63:0]     msg_data;
   logic            msg_last;
   logic [3:0]      msg_bytes;
   logic [BITS-1:0] core_in;
   logic            core_in_valid;
   logic            core_more;
   logic            core_hash_next;
   logic            core_out_valid;
   logic            busy;

   sha3_msg_padder dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .msg_valid      (msg_valid),
      .msg_ready      (msg_ready),
      .msg_data       (msg_data),
      .msg_last       (msg_last),
      .msg_bytes      (msg_bytes),
      .core_in        (core_in),
      .core_in_valid  (core_in_valid),
      .core_more      (core_more),
      .core_hash_next (core_hash_next),
      .core_out_valid (core_out_valid),
      .busy           (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [BITS-1:0] blk;
      logic            more;
   } exp_t;

   exp_t       sb_q[$];
   logic [7:0] msg_b[$];
   int         checks = 0;
   int         errors = 0;
   int         cyc = 0;
   int         hn_delay = 2;
   int         fin_delay = 3;
   int         cstate = 0;
   int         ccnt = 0;
   bit         gap_en = 1'b1;
   bit         abc_mode = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference: message || 0x06 || 0.. || 0x80 up to a multiple of 136 bytes, split into blocks
   task automatic push_expected();
      logic [7:0] p[$];
      logic [7:0] bv;
      exp_t       e;
      int         nblk;
      p = msg_b;
      p.push_back(8'h06);
      while (p.size() % RB != 0) p.push_back(8'h00);
      p[p.size()-1] = p[p.size()-1] | 8'h80;
      nblk = p.size() / RB;
      for (int b = 0; b < nblk; b++) begin
         e.blk = '0;
         for (int n = 0; n < RB; n++) begin
            bv = p[b*RB + n];
            for (int j = 0; j < 8; j++) e.blk[BITS-1-8*n-j] = bv[j];
         end
         e.more = (b < nblk - 1);
         sb_q.push_back(e);
      end
   endtask

   task automatic send_word(input logic [63:0] d, input logic last, input logic [3:0] nb);
      int t;
      t = 0;
      msg_valid = 1'b1;
      msg_data  = d;
      msg_last  = last;
      msg_bytes = nb;
      forever begin
         @(negedge clk);
         if (msg_ready) break;
         t++;
         if (t > 2000) break;
      end
      if (t > 2000) begin
         checks++;
         errors++;
         $display("FAIL word accept timeout: msg_ready %0b after %0d cycles, expected 1", msg_ready, t);
      end
      @(posedge clk);
      #1;
      msg_valid = 1'b0;
   endtask

   task automatic send_msg(input int len, input int abort_after);
      int         nw;
      int         nb;
      logic [63:0] d;
      logic [3:0] fld;
      logic       lastb;
      msg_b.delete();
      for (int i = 0; i < len; i++)
         msg_b.push_back(abc_mode ? 8'(8'h61 + i) : 8'($urandom));
      nw = (len == 0) ? 1 : (len + 7) / 8;
      if (abort_after == 0) push_expected();
      for (int w = 0; w < nw; w++) begin
         if (abort_after > 0 && w == abort_after) return;
         d     = {$urandom, $urandom};
         lastb = (w == nw - 1);
         nb    = lastb ? len - 8*w : 8;
         for (int k = 0; k < 8; k++) if (k < nb) d[8*k +: 8] = msg_b[8*w + k];
         fld = lastb ? 4'(nb) : 4'($urandom);
         if (lastb && nb == 8 && $urandom_range(0, 1) == 1) fld = 4'(8 + $urandom_range(1, 7));
         send_word(d, lastb, fld);
         if (gap_en && $urandom_range(0, 3) == 0)
            repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
      end
   endtask

   task automatic wait_idle();
      int t;
      t = 0;
      while (!(sb_q.size() == 0 && cstate == 0 && !busy) && t < 3000) begin
         @(negedge clk);
         t++;
      end
      checks++;
      if (t >= 3000) begin
         errors++;
         $display("FAIL drain timeout: %0d blocks outstanding busy=%0b, expected 0", sb_q.size(), busy);
      end
      repeat (2) @(posedge clk);
      #1;
   endtask

   // Core model: hash_next after hn_delay following a more=1 block, out_valid after a final one
   initial begin
      logic got, gm;
      core_hash_next = 1'b0;
      core_out_valid = 1'b0;
      forever begin
         @(negedge clk);
         got = rst_n && core_in_valid;
         gm  = core_more;
         if (got) begin
            checks++;
            if (cstate == 2 || (cstate == 1 && !core_hash_next)) begin
               errors++;
               $display("FAIL core handshake: block issued in core state %0d hash_next=%0b, expected idle or hash_next=1",
                        cstate, core_hash_next);
            end
         end
         @(posedge clk);
         #1;
         core_out_valid = 1'b0;
         if (!rst_n) begin
            core_hash_next = 1'b0;
            cstate = 0;
            ccnt   = 0;
         end else if (got) begin
            core_hash_next = 1'b0;
            cstate = gm ? 1 : 2;
            ccnt   = gm ? hn_delay : fin_delay;
         end else if (ccnt > 0) begin
            ccnt--;
         end else if (cstate == 1) begin
            core_hash_next = 1'b1;
         end else if (cstate == 2) begin
            core_out_valid = 1'b1;
            cstate = 0;
         end
      end
   end

   // Scoreboard monitor
   initial begin
      exp_t e;
      int   fb;
      forever begin
         @(negedge clk);
         if (rst_n && core_in_valid) begin
            checks++;
            if (sb_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected block: core_in_valid 1 with no block expected");
            end else begin
               e = sb_q.pop_front();
               if (core_in !== e.blk || core_more !== e.more) begin
                  errors++;
                  fb = -1;
                  for (int n = 0; n < RB; n++)
                     if (fb < 0 && core_in[BITS-1-8*n -: 8] !== e.blk[BITS-1-8*n -: 8]) fb = n;
                  if (fb < 0) fb = 0;
                  $display("FAIL block issue: byte %0d got %02h expected %02h, more got %0b expected %0b",
                           fb, core_in[BITS-1-8*fb -: 8], e.blk[BITS-1-8*fb -: 8], core_more, e.more);
               end
            end
         end
      end
   end

   initial begin
      int ready_hi, waited;
      logic got_iv, hn_seen;
      int bounds[13] = '{0, 7, 8, 9, 127, 128, 134, 135, 136, 137, 271, 272, 273};

      msg_valid = 1'b0;
      msg_data  = '0;
      msg_last  = 1'b0;
      msg_bytes = '0;
      rst_n     = 1'b0;
      #3;
      chk("reset msg_ready", msg_ready, 1);
      chk("reset core_in_valid", core_in_valid, 0);
      chk("reset core_more", core_more, 0);
      chk("reset busy", busy, 0);
      chk("reset core_in nonzero", |core_in, 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Empty message: block must be issued the cycle after the last word
      send_msg(0, 0);
      @(negedge clk);
      chk("empty msg issue latency", core_in_valid, 1);
      wait_idle();

      abc_mode = 1'b1;
      send_msg(3, 0);
      abc_mode = 1'b0;
      @(negedge clk);
      chk("abc issue latency", core_in_valid, 1);
      wait_idle();

      send_msg(135, 0);
      wait_idle();

      hn_delay = 5;
      send_msg(136, 0);
      wait_idle();

      // Long hash_next wait on the second block
      gap_en   = 1'b0;
      hn_delay = 40;
      send_msg(200, 0);
      ready_hi = 0;
      waited   = 0;
      got_iv   = 1'b0;
      hn_seen  = 1'b0;
      for (int t = 0; t < 200; t++) begin
         @(negedge clk);
         if (core_in_valid) begin
            got_iv  = 1'b1;
            hn_seen = core_hash_next;
            break;
         end
         if (msg_ready) ready_hi++;
         waited++;
      end
      chk("200B block2 issued", got_iv, 1);
      chk("200B ready low during wait", ready_hi, 0);
      chk("200B wait length >= 15", waited >= 15, 1);
      chk("200B issue with hash_next", hn_seen, 1);
      gap_en = 1'b1;
      wait_idle();

      // Back-to-back: second message's first block must wait for out_valid
      hn_delay  = 2;
      fin_delay = 30;
      send_msg(10, 0);
      send_msg(20, 0);
      @(negedge clk);
      chk("b2b second block held", core_in_valid, 0);
      chk("b2b busy while held", busy, 1);
      wait_idle();

      // Reset in the middle of a message
      fin_delay = 3;
      send_msg(60, 4);
      chk("partial msg busy", busy, 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("midreset msg_ready", msg_ready, 1);
      chk("midreset core_in_valid", core_in_valid, 0);
      chk("midreset core_more", core_more, 0);
      chk("midreset busy", busy, 0);
      chk("midreset core_in nonzero", |core_in, 0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      send_msg(0, 0);
      wait_idle();

      for (int r = 0; r < 33; r++) begin
         hn_delay  = $urandom_range(0, 6);
         fin_delay = $urandom_range(0, 8);
         send_msg((r < 13) ? bounds[r] : $urandom_range(0, 420), 0);
         if ($urandom_range(0, 1) == 1) wait_idle();
      end
      wait_idle();
      chk("final busy", busy, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
